// File: rtl/route_fabric_nxm.sv
// NUM_IN lanes steered to NUM_OUT per-destination FIFOs with per-output round-robin arbitration.
// Optional ROUTE_PARITY_EN: lanes carry an MSB even-parity bit; bad words are dropped and flagged on par_err.
module route_fabric_nxm #(
  parameter int DATA_W     = 8,
  parameter int NUM_IN     = 2,
  parameter int NUM_OUT    = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int AF_THRESH  = 6,
  parameter int AE_THRESH  = 2,
  localparam int DEST_W    = $clog2(NUM_OUT),
`ifdef ROUTE_PARITY_EN
  localparam int LANE_W    = DEST_W + DATA_W + 1
`else
  localparam int LANE_W    = DEST_W + DATA_W
`endif
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_IN*LANE_W-1:0]    in_data,
  input  logic [NUM_IN-1:0]           in_valid,
  output logic [NUM_IN-1:0]           in_stall,
`ifdef ROUTE_PARITY_EN
  output logic [NUM_IN-1:0]           par_err,
`endif
  input  logic [NUM_OUT-1:0]          read,
  output logic [NUM_OUT*DATA_W-1:0]   out_data,
  output logic [NUM_OUT-1:0]          out_valid,
  output logic [NUM_OUT-1:0]          fifo_full,
  output logic [NUM_OUT-1:0]          fifo_empty,
  output logic [NUM_OUT-1:0]          almost_full,
  output logic [NUM_OUT-1:0]          almost_empty,
  output logic [NUM_OUT-1:0]          fifo_pause,
  output logic [NUM_OUT-1:0]          fifo_error
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] CNT_AE   = CNT_W'(AE_THRESH);
  localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_IN - 1);

`ifdef ROUTE_PARITY_EN
  function automatic logic parity_ok(input logic [LANE_W-1:0] word);
    return ~(^word);
  endfunction
`endif

  logic [DEST_W-1:0] lane_dest_s [NUM_IN];
  logic [DATA_W-1:0] lane_pay_s  [NUM_IN];
  logic [NUM_IN-1:0] lane_ok_s;
  logic [NUM_IN-1:0] lane_grant_s;

  logic [IDX_W-1:0]  rr_ptr_r [NUM_OUT];
  logic [IDX_W-1:0]  rr_nxt_s [NUM_OUT];
  logic [IDX_W-1:0]  win_s    [NUM_OUT];
  logic [NUM_OUT-1:0] wr_en_s;
  logic [NUM_OUT-1:0] rd_en_s;

  logic [PTR_W-1:0]  wr_ptr_r [NUM_OUT];
  logic [PTR_W-1:0]  rd_ptr_r [NUM_OUT];
  logic [CNT_W-1:0]  count_r  [NUM_OUT];
  logic [DATA_W-1:0] mem_r    [NUM_OUT][FIFO_DEPTH];
  logic [DATA_W-1:0] out_data_r [NUM_OUT];
  logic [NUM_OUT-1:0] out_valid_r;
  logic [NUM_OUT-1:0] fifo_error_r;

  // Split each lane word into destination, payload and parity status.
  always_comb begin
    for (int i = 0; i < NUM_IN; i++) begin
      lane_pay_s[i]  = in_data[i*LANE_W +: DATA_W];
      lane_dest_s[i] = in_data[i*LANE_W + DATA_W +: DEST_W];
`ifdef ROUTE_PARITY_EN
      lane_ok_s[i]   = parity_ok(in_data[i*LANE_W +: LANE_W]);
`else
      lane_ok_s[i]   = 1'b1;
`endif
    end
  end

  // Per-output round-robin: first requester at or after rr_ptr wins unless the FIFO is full.
  always_comb begin : arb
    int   idx;
    logic hit;
    idx          = 0;
    hit          = 1'b0;
    lane_grant_s = '0;
    wr_en_s      = '0;
    rd_en_s      = '0;
    for (int o = 0; o < NUM_OUT; o++) begin
      win_s[o]    = IDX_ZERO;
      rr_nxt_s[o] = rr_ptr_r[o];
      rd_en_s[o]  = read[o] & (count_r[o] != CNT_ZERO);
      for (int k = 0; k < NUM_IN; k++) begin
        idx = (int'(rr_ptr_r[o]) + k) % NUM_IN;
        hit = ~wr_en_s[o] & (count_r[o] != CNT_FULL) & in_valid[idx] & lane_ok_s[idx]
              & (lane_dest_s[idx] == DEST_W'(o));
        wr_en_s[o]        = wr_en_s[o] | hit;
        lane_grant_s[idx] = lane_grant_s[idx] | hit;
        win_s[o]          = hit ? IDX_W'(idx) : win_s[o];
        rr_nxt_s[o]       = hit ? ((IDX_W'(idx) == IDX_LAST) ? IDX_ZERO : IDX_W'(idx) + IDX_ONE)
                                : rr_nxt_s[o];
      end
    end
  end

  assign in_stall = in_valid & lane_ok_s & ~lane_grant_s;

  // FIFO storage; contents are don't-care after reset because pointers and counts clear.
  always_ff @(posedge clk) begin
    for (int o = 0; o < NUM_OUT; o++) begin
      if (wr_en_s[o]) begin
        mem_r[o][wr_ptr_r[o]] <= lane_pay_s[win_s[o]];
      end
    end
  end

  // Pointers, counts, arbitration state and the registered read port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_r  <= '0;
      fifo_error_r <= '0;
      for (int o = 0; o < NUM_OUT; o++) begin
        wr_ptr_r[o]   <= PTR_ZERO;
        rd_ptr_r[o]   <= PTR_ZERO;
        count_r[o]    <= CNT_ZERO;
        rr_ptr_r[o]   <= IDX_ZERO;
        out_data_r[o] <= '0;
      end
    end else begin
      for (int o = 0; o < NUM_OUT; o++) begin
        rr_ptr_r[o]    <= rr_nxt_s[o];
        out_valid_r[o] <= rd_en_s[o];
        count_r[o]     <= count_r[o] + (wr_en_s[o] ? CNT_ONE : CNT_ZERO)
                                     - (rd_en_s[o] ? CNT_ONE : CNT_ZERO);
        if (wr_en_s[o]) begin
          wr_ptr_r[o] <= wr_ptr_r[o] + PTR_ONE;
        end
        if (rd_en_s[o]) begin
          rd_ptr_r[o]   <= rd_ptr_r[o] + PTR_ONE;
          out_data_r[o] <= mem_r[o][rd_ptr_r[o]];
        end
        if (read[o] && !rd_en_s[o]) begin
          fifo_error_r[o] <= 1'b1;
        end
      end
    end
  end

`ifdef ROUTE_PARITY_EN
  logic [NUM_IN-1:0] par_err_r;

  // Sticky per-lane record of words dropped for bad parity.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      par_err_r <= '0;
    end else begin
      par_err_r <= par_err_r | (in_valid & ~lane_ok_s);
    end
  end

  assign par_err = par_err_r;
`endif

  for (genvar o = 0; o < NUM_OUT; o++) begin : g_out
    assign out_data[o*DATA_W +: DATA_W] = out_data_r[o];
    assign fifo_full[o]    = (count_r[o] == CNT_FULL);
    assign fifo_empty[o]   = (count_r[o] == CNT_ZERO);
    assign almost_full[o]  = (count_r[o] >= CNT_AF);
    assign almost_empty[o] = (count_r[o] <= CNT_AE);
  end

  assign fifo_pause = almost_full;
  assign out_valid  = out_valid_r;
  assign fifo_error = fifo_error_r;

endmodule

// File: doc/route_fabric_nxm.md
Name: route_fabric_nxm

Overview:
- Parametrised successor to the two-port PCIe router: NUM_IN input lanes steered to NUM_OUT per-destination FIFOs.
- The destination is carried in the upper bits of each input word.
- Adds:
  - per-output round-robin arbitration between contending inputs;
  - per-input stall backpressure;
  - registered read port with out_valid;
  - programmable almost-full/almost-empty thresholds.
- Sits between the lane receivers and the downstream link-layer consumers.

Parameters:
DATA_W, 8, payload width per word
NUM_IN, 2, number of input lanes (>=1)
NUM_OUT, 4, number of output FIFOs (power of 2, >=2)
DEST_W, $clog2(NUM_OUT), destination field width (derived, localparam)
FIFO_DEPTH, 8, entries per output FIFO (power of 2)
AF_THRESH, 6, almost_full asserted when count >= AF_THRESH
AE_THRESH, 2, almost_empty asserted when count <= AE_THRESH

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
in_data  input  NUM_IN*(DEST_W+DATA_W)  lane i word = {dest, payload} at slice i
in_valid  input  NUM_IN  lane i word present
in_stall  output  NUM_IN  combinational; lane i must hold word next cycle
read  input  NUM_OUT  pop request per output FIFO
out_data  output  NUM_OUT*DATA_W  registered popped payload
out_valid  output  NUM_OUT  out_data slice valid (one-cycle pulse per pop)
fifo_full  output  NUM_OUT  count == FIFO_DEPTH
fifo_empty  output  NUM_OUT  count == 0
almost_full  output  NUM_OUT  count >= AF_THRESH
almost_empty  output  NUM_OUT  count <= AE_THRESH
fifo_pause  output  NUM_OUT  equals almost_full; upstream flow-control hint
fifo_error  output  NUM_OUT  sticky: read while empty

Behaviour:
- Reset (reset==0, async) clears:
  - all pointers and counts;
  - RR pointers (to input 0);
  - out_data = 0, out_valid = 0, fifo_error = 0.
- Consequently fifo_empty = 1, almost_empty = 1, and all other flags are 0.
- Reset mid-operation discards all stored words. The first write is accepted on the first rising edge after release.
- Arbitration, per output o, each cycle:
  - Requesters are the lanes with in_valid=1 and dest==o.
  - If fifo_full[o], no requester is granted.
  - Otherwise, one grant goes to the first requester at or after rr_ptr[o], wrapping modulo NUM_IN.
  - On a grant, rr_ptr[o] <= granted+1 (mod NUM_IN); with no grant it holds.
- in_stall[i] = in_valid[i] & ~grant[i]. It is purely combinational from in_valid, in_data dest fields, the registered counts and rr_ptr.
  - A stalled lane must hold its word unchanged.
  - in_stall is 0 when in_valid is 0.
- Write: a granted word's payload is written at wr_ptr[o] on the rising edge, then wr_ptr increments mod FIFO_DEPTH. Across all outputs, at most NUM_OUT writes per cycle and at most one per FIFO.
- Read:
  - read[o] with count>0 pops on the edge: out_data slice <= mem[rd_ptr], out_valid[o] <= 1, rd_ptr increments. Latency is one cycle.
  - read[o] with count==0 performs no pop: out_valid[o] <= 0, fifo_error[o] <= 1 (sticky until reset), and out_data holds.
  - If not reading, out_valid[o] <= 0 and out_data holds.
- Simultaneous events:
  - Write+read on a non-empty, non-full FIFO: count unchanged, both pointers advance.
  - Write+read on an empty FIFO: the write is accepted; the read flags an error and returns nothing. The written word is readable next cycle.
  - Full FIFO: the write is blocked even if a read occurs the same cycle, because full is registered.
- Flags derive from registered count (width $clog2(FIFO_DEPTH)+1) and update the cycle after the causing edge.

Optional Feature:
ROUTE_PARITY_EN:
- Defined:
  - Each lane word gains an MSB even-parity bit over {dest, payload}, making the lane width DEST_W+DATA_W+1.
  - A word with bad parity is not granted and not stalled; it is dropped and consumes one cycle.
  - Output port par_err [NUM_IN] sets the sticky bit for that lane; it clears on reset.
- Undefined: no parity bit, no par_err port, all valid words route.

Test Plan:
Defaults, lane word = 10 bits:
1. Reset: hold reset=0 for 3 cycles, then release -> fifo_empty=4'hF, almost_empty=4'hF, fifo_error=0, out_valid=0, in_stall=0.
2. Single route: lane0 sends {2'd2, 8'hFF} for 1 cycle, then read[2]=1 for 1 cycle -> out_data[23:16]=8'hFF with out_valid[2]=1 one cycle after read; fifo_empty[2] returns to 1.
3. Contention: both lanes valid with dest=1 (8'hDD lane0, 8'hCC lane1) held for 2 cycles -> cycle 1: lane0 granted, in_stall=2'b10; cycle 2: lane1 granted; reads return DD then CC.
4. Fill: lane0 writes 8 words to dest 3 with read[3]=0:
   - almost_full[3]/fifo_pause[3] rise after the 6th write;
   - fifo_full[3] rises after the 8th;
   - a 9th word sees in_stall[0]=1 until read[3] pulses, then is accepted.
5. Empty read: read[0]=1 on an empty FIFO -> fifo_error[0]=1 next cycle and stays 1; out_valid[0]=0. Same-cycle write+read on empty: the word is later read correctly.
6. Reset mid-operation: FIFO 1 holds 5 words; pulse reset=0 asynchronously between edges -> flags reset immediately; the next read[1] sets fifo_error[1].
